// File: rtl/glitch_pkg.sv
// rtl/glitch_pkg.sv - shared widths and FSM state type for the glitch sequencer
package glitch_pkg;

  localparam int DELAY_W   = 16;
  localparam int WIDTH_W   = 8;
  localparam int COUNT_W   = 8;
  localparam int SPACING_W = 16;
  localparam int RSTLEN_W  = 16;
  localparam int TIMER_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    DELAY,
    PULSE,
    SPACE,
    DONE
  } state_t;

endpackage

// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable down-counter with zero flag, stops at zero
module down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);

  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && count != '0) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - optional target reset, then delay and a train of glitch pulses
module glitch_sequencer
  import glitch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DELAY_W-1:0]   delay_i,
  input  logic [WIDTH_W-1:0]   width_i,
  input  logic [COUNT_W-1:0]   num_pulses_i,
  input  logic [SPACING_W-1:0] pulse_spacing_i,
  input  logic [RSTLEN_W-1:0]  reset_length_i,
  input  logic                 pulse_en_i,
  input  logic                 reset_en_i,
  output logic                 glitch_o,
  output logic                 target_rst_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [TIMER_W-1:0] ONE = 1;
  localparam logic [COUNT_W-1:0] ONE_PULSE = 1;

  state_t               state;
  state_t               nxt;
  logic [DELAY_W-1:0]   delay_q;
  logic [WIDTH_W-1:0]   width_q;
  logic [COUNT_W-1:0]   num_q;
  logic [SPACING_W-1:0] spacing_q;
  logic [COUNT_W-1:0]   pulses_left;

  logic                 start;
  logic [DELAY_W-1:0]   src_delay;
  logic [WIDTH_W-1:0]   src_width;
  logic [COUNT_W-1:0]   src_num;
  logic                 chain_delay;
  logic                 chain_pulse;

  logic                 timer_load;
  logic                 timer_en;
  logic [TIMER_W-1:0]   timer_value;
  logic                 timer_zero;

  // Phase lengths are loaded as (n-1) so each phase lasts exactly n cycles.
  down_counter #(.W(TIMER_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .en    (timer_en),
    .value (timer_value),
    .zero  (timer_zero)
  );

  assign start     = (state == IDLE) && (pulse_en_i || reset_en_i);
  assign src_delay = (state == IDLE) ? delay_i      : delay_q;
  assign src_width = (state == IDLE) ? width_i      : width_q;
  assign src_num   = (state == IDLE) ? num_pulses_i : num_q;

  // Zero-length phases fall through to the next phase in the same cycle.
  always_comb begin
    nxt         = state;
    timer_load  = 1'b0;
    timer_en    = 1'b0;
    timer_value = '0;
    chain_delay = 1'b0;
    chain_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (reset_en_i && reset_length_i != '0) begin
            nxt         = RESET;
            timer_load  = 1'b1;
            timer_value = reset_length_i - ONE;
          end else begin
            chain_delay = 1'b1;
          end
        end
      end
      RESET: begin
        if (timer_zero) chain_delay = 1'b1;
        else            timer_en    = 1'b1;
      end
      DELAY: begin
        if (timer_zero) chain_pulse = 1'b1;
        else            timer_en    = 1'b1;
      end
      PULSE: begin
        if (timer_zero) begin
          if (pulses_left == ONE_PULSE) begin
            nxt = DONE;
          end else begin
            nxt         = SPACE;
            timer_load  = 1'b1;
            timer_value = (spacing_q == '0) ? '0 : spacing_q - ONE;
          end
        end else begin
          timer_en = 1'b1;
        end
      end
      SPACE: begin
        if (timer_zero) begin
          nxt         = PULSE;
          timer_load  = 1'b1;
          timer_value = TIMER_W'(width_q) - ONE;
        end else begin
          timer_en = 1'b1;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase

    if (chain_delay) begin
      if (src_delay != '0) begin
        nxt         = DELAY;
        timer_load  = 1'b1;
        timer_value = src_delay - ONE;
      end else begin
        chain_pulse = 1'b1;
      end
    end

    if (chain_pulse) begin
      if (src_width == '0 || src_num == '0) begin
        nxt = DONE;
      end else begin
        nxt         = PULSE;
        timer_load  = 1'b1;
        timer_value = TIMER_W'(src_width) - ONE;
      end
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      glitch_o     <= 1'b0;
      target_rst_o <= 1'b0;
      done_o       <= 1'b0;
      delay_q      <= '0;
      width_q      <= '0;
      num_q        <= '0;
      spacing_q    <= '0;
      pulses_left  <= '0;
    end else begin
      state        <= nxt;
      glitch_o     <= (nxt == PULSE);
      target_rst_o <= (nxt == RESET);
      done_o       <= (nxt == DONE);
      if (start) begin
        delay_q   <= delay_i;
        width_q   <= width_i;
        num_q     <= num_pulses_i;
        spacing_q <= pulse_spacing_i;
      end
      if (nxt == PULSE && (state == IDLE || state == RESET || state == DELAY)) begin
        pulses_left <= src_num;
      end else if (state == PULSE && nxt == SPACE) begin
        pulses_left <= pulses_left - ONE_PULSE;
      end
    end
  end

  // The reset length goes straight into the phase timer at the strobe, so it needs no holding register.
  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb/tb_glitch_sequencer.sv - directed table-driven bench for glitch_sequencer
module tb_glitch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] delay;
  logic [7:0]  width;
  logic [7:0]  num_pulses;
  logic [15:0] spacing;
  logic [15:0] reset_length;
  logic        pulse_en;
  logic        reset_en;
  logic        glitch;
  logic        target_rst;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cur_vec = 0;

  always #5 clk = ~clk;

  glitch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .delay_i         (delay),
    .width_i         (width),
    .num_pulses_i    (num_pulses),
    .pulse_spacing_i (spacing),
    .reset_length_i  (reset_length),
    .pulse_en_i      (pulse_en),
    .reset_en_i      (reset_en),
    .glitch_o        (glitch),
    .target_rst_o    (target_rst),
    .busy_o          (busy),
    .done_o          (done)
  );

  // Edge indices: 1 = value seen just before the first edge after the strobe edge.
  typedef struct {
    logic [15:0] d;
    logic [7:0]  w;
    logic [7:0]  n;
    logic [15:0] sp;
    logic [15:0] rl;
    bit          pe;
    bit          re;
    int          e_rst_first;
    int          e_rst_cnt;
    int          e_gl_first;
    int          e_gl_cnt;
    int          e_gl_rises;
    int          e_done;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec%0d: got %0d expected %0d", name, cur_vec, act, exp);
    end
  endtask

  task automatic run_vector(input vec_t v);
    int   rst_first = 0, rst_cnt = 0, gl_first = 0, gl_cnt = 0, rises = 0;
    int   done_at = 0, done_cnt = 0, busy_gap = 0, overlap = 0, busy_after = 1;
    logic prev_gl = 1'b0;
    @(negedge clk);
    delay = v.d; width = v.w; num_pulses = v.n; spacing = v.sp; reset_length = v.rl;
    pulse_en = v.pe; reset_en = v.re;
    @(posedge clk);
    #1;
    pulse_en = 1'b0; reset_en = 1'b0;
    delay = 16'd7; width = 8'd9; num_pulses = 8'd5; spacing = 16'd2; reset_length = 16'd3;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (target_rst) begin
        if (rst_first == 0) rst_first = i;
        rst_cnt++;
      end
      if (glitch) begin
        if (gl_first == 0) gl_first = i;
        gl_cnt++;
        if (!prev_gl) rises++;
      end
      prev_gl = glitch;
      if (glitch && target_rst) overlap++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end
      if ((done_at == 0 || i == done_at) && !busy) busy_gap++;
      if (done_at != 0 && i == done_at + 1) busy_after = int'(busy);
      if (i == 1) pulse_en = 1'b1;
      if (i == 2) pulse_en = 1'b0;
      if (done_at != 0 && i >= done_at + 3) break;
    end
    check("rst_first",  rst_first, v.e_rst_first);
    check("rst_cnt",    rst_cnt,   v.e_rst_cnt);
    check("gl_first",   gl_first,  v.e_gl_first);
    check("gl_cnt",     gl_cnt,    v.e_gl_cnt);
    check("gl_rises",   rises,     v.e_gl_rises);
    check("done_at",    done_at,   v.e_done);
    check("done_cnt",   done_cnt,  1);
    check("busy_gap",   busy_gap,  0);
    check("overlap",    overlap,   0);
    check("busy_after", busy_after, 0);
  endtask

  initial begin
    int idx;
    int seen;
    rst = 1'b1;
    delay = '0; width = '0; num_pulses = '0; spacing = '0; reset_length = '0;
    pulse_en = 1'b0; reset_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_glitch", int'(glitch), 0);
    check("rst_trst",   int'(target_rst), 0);
    check("rst_busy",   int'(busy), 0);
    check("rst_done",   int'(done), 0);

    pulse_en = 1'b1; reset_en = 1'b1; reset_length = 16'd5; width = 8'd1; num_pulses = 8'd1;
    @(posedge clk);
    #1;
    rst = 1'b0; pulse_en = 1'b0; reset_en = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || target_rst || glitch || done) seen++;
    end
    check("strobe_in_rst", seen, 0);

    //           d       w      n       sp      rl     pe re rf rc gf  gc   gr  done
    vecs[0] = '{16'd10, 8'd3,  8'd1,   16'd0, 16'd0, 1, 0, 0, 0, 11, 3,   1,   14};
    vecs[1] = '{16'd0,  8'd2,  8'd3,   16'd4, 16'd0, 1, 0, 0, 0, 1,  6,   3,   15};
    vecs[2] = '{16'd2,  8'd1,  8'd1,   16'd0, 16'd5, 0, 1, 1, 5, 8,  1,   1,   9};
    vecs[3] = '{16'd1,  8'd1,  8'd2,   16'd0, 16'd0, 1, 1, 0, 0, 2,  2,   2,   5};
    vecs[4] = '{16'd3,  8'd0,  8'd4,   16'd0, 16'd0, 1, 0, 0, 0, 0,  0,   0,   4};
    vecs[5] = '{16'd0,  8'd5,  8'd0,   16'd0, 16'd0, 1, 0, 0, 0, 0,  0,   0,   1};
    vecs[6] = '{16'd0,  8'd1,  8'd1,   16'd0, 16'd1, 1, 1, 1, 1, 2,  1,   1,   3};
    vecs[7] = '{16'd0,  8'd1,  8'd3,   16'd0, 16'd0, 1, 0, 0, 0, 1,  3,   3,   6};
    vecs[8] = '{16'd0,  8'd255, 8'd2,  16'd5, 16'd0, 1, 0, 0, 0, 1,  510, 2,   516};
    vecs[9] = '{16'd0,  8'd1,  8'd255, 16'd1, 16'd0, 1, 0, 0, 0, 1,  255, 255, 510};

    for (int k = 0; k < 10; k++) begin
      cur_vec = k;
      run_vector(vecs[k]);
    end

    cur_vec = 100;
    @(negedge clk);
    delay = 16'hffff; width = 8'd4; num_pulses = 8'd1; spacing = 16'd0; reset_length = 16'd0;
    pulse_en = 1'b1;
    @(posedge clk);
    #1;
    pulse_en = 1'b0;
    @(negedge clk);
    idx = 1;
    while (!glitch && idx < 70000) begin
      @(negedge clk);
      idx++;
    end
    check("long_delay_first", idx, 65536);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_glitch", int'(glitch), 0);
    check("abort_trst",   int'(target_rst), 0);
    check("abort_busy",   int'(busy), 0);
    check("abort_done",   int'(done), 0);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort_quiet", seen, 0);

    cur_vec = 101;
    run_vector(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
